// File: rtl/rgb_led_scheduler.sv
// Round-robin owner of a single RGB LED: per-owner PWM with a minimum hold of
// whole PWM periods and one dark PWM period between successive owners.
module rgb_led_scheduler #(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned PWM_BITS  = 4,
    parameter int unsigned HOLD_BITS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [3*PWM_BITS*N_REQ-1:0] duty,
    output logic [N_REQ-1:0]            grant,
    output logic                        red,
    output logic                        green,
    output logic                        blue,
    output logic                        busy
);

    localparam int unsigned IDX_W    = $clog2(N_REQ);
    localparam int unsigned IDX_W1   = IDX_W + 1;
    localparam int unsigned DUTY_W   = 3 * PWM_BITS;
    localparam int unsigned HOLD_W   = HOLD_BITS + 1;
    localparam int unsigned HOLD_MAX = 1 << HOLD_BITS;
    localparam int unsigned PWM_MAX  = (1 << PWM_BITS) - 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHOW = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]          state, state_d;
    logic [PWM_BITS-1:0] pwm_cnt, pwm_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_d, hold_inc;
    logic [IDX_W-1:0]    ptr, ptr_d;
    logic [IDX_W-1:0]    owner, owner_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [N_REQ-1:0]    grant_d;
    logic                red_d, green_d, blue_d, show_d, pwm_end, others_req;

    logic                win_found;
    logic [IDX_W-1:0]    win;
    logic [IDX_W1-1:0]   idx;
    logic [DUTY_W-1:0]   duty_win, duty_own;

    // First requester at or after the rr pointer, wrapping
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + IDX_W1'(i);
            if (idx >= IDX_W1'(N_REQ)) idx = idx - IDX_W1'(N_REQ);
            if (!win_found && req[idx[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win       = idx[IDX_W-1:0];
            end
        end
    end

    // Duty words of the arbitration winner and of the current owner
    always_comb begin
        duty_win = '0;
        duty_own = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IDX_W'(i))   duty_win = duty[DUTY_W*i +: DUTY_W];
            if (owner == IDX_W'(i)) duty_own = duty[DUTY_W*i +: DUTY_W];
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state;
        pwm_d      = pwm_cnt;
        hold_d     = hold_cnt;
        ptr_d      = ptr;
        owner_d    = owner;
        duty_d     = duty_q;
        grant_d    = grant;
        hold_inc   = hold_cnt + HOLD_W'(1);
        pwm_end    = (pwm_cnt == PWM_BITS'(PWM_MAX));
        others_req = |(req & ~grant);
        case (state)
            IDLE: begin
                pwm_d   = '0;
                hold_d  = '0;
                grant_d = '0;
                if (win_found) begin
                    state_d = SHOW;
                    owner_d = win;
                    grant_d = N_REQ'(1) << win;
                    duty_d  = duty_win;
                end
            end
            SHOW: begin
                pwm_d = pwm_cnt + PWM_BITS'(1);
                if (pwm_end) begin
                    hold_d = (hold_cnt == HOLD_W'(HOLD_MAX)) ? hold_cnt : hold_inc;
                    duty_d = duty_own;
                    // Release only once the minimum hold is met
                    if (hold_inc >= HOLD_W'(HOLD_MAX) && (!req[owner] || others_req)) begin
                        state_d = GAP;
                        grant_d = '0;
                        ptr_d   = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
                    end
                end
            end
            GAP: begin
                pwm_d = pwm_cnt + PWM_BITS'(1);
                if (pwm_end) begin
                    hold_d = '0;
                    if (win_found) begin
                        state_d = SHOW;
                        owner_d = win;
                        grant_d = N_REQ'(1) << win;
                        duty_d  = duty_win;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Drive levels for the coming cycle, compared against the coming pwm phase
    always_comb begin
        show_d  = (state_d == SHOW);
        red_d   = show_d && (pwm_d < duty_d[DUTY_W-1 -: PWM_BITS]);
        green_d = show_d && (pwm_d < duty_d[2*PWM_BITS-1 -: PWM_BITS]);
        blue_d  = show_d && (pwm_d < duty_d[PWM_BITS-1:0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pwm_cnt  <= '0;
            hold_cnt <= '0;
            ptr      <= '0;
            owner    <= '0;
            duty_q   <= '0;
            grant    <= '0;
            red      <= 1'b0;
            green    <= 1'b0;
            blue     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            pwm_cnt  <= pwm_d;
            hold_cnt <= hold_d;
            ptr      <= ptr_d;
            owner    <= owner_d;
            duty_q   <= duty_d;
            grant    <= grant_d;
            red      <= red_d;
            green    <= green_d;
            blue     <= blue_d;
            busy     <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// Bench for rgb_led_scheduler: directed scenarios plus random traffic, checked
// every cycle against an owner/age reference model.
module tb_rgb_led_scheduler;

    localparam int N    = 3;
    localparam int PB   = 2;
    localparam int HB   = 1;
    localparam int P    = 1 << PB;
    localparam int HOLD = 1 << HB;
    localparam int DW   = 3 * PB * N;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic [DW-1:0] duty;
    logic [N-1:0]  grant;
    logic          red, green, blue, busy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: current owner (-1 none), clocks since grant, gap age
    int m_owner, m_age, m_gap, m_gap_age, m_ptr, m_dr, m_dg, m_db;

    rgb_led_scheduler #(.N_REQ(N), .PWM_BITS(PB), .HOLD_BITS(HB)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .duty  (duty),
        .grant (grant),
        .red   (red),
        .green (green),
        .blue  (blue),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int chan(input int i, input int ch);
        return int'(duty[PB*(3*i + 2 - ch) +: PB]);
    endfunction

    task automatic set_duty(input int i, input int r, input int g, input int b);
        duty[PB*(3*i+2) +: PB] = PB'(r);
        duty[PB*(3*i+1) +: PB] = PB'(g);
        duty[PB*(3*i)   +: PB] = PB'(b);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_gap = 0; m_gap_age = 0; m_ptr = 0;
        m_dr = 0; m_dg = 0; m_db = 0;
    endtask

    task automatic model_grant();
        int w;
        w = -1;
        for (int i = N - 1; i >= 0; i--)
            if (req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
        if (w >= 0) begin
            m_owner = w; m_age = 0;
            m_dr = chan(w, 0); m_dg = chan(w, 1); m_db = chan(w, 2);
        end
    endtask

    // Advance the model across one clock edge using the inputs now applied
    task automatic model_next();
        logic [N-1:0] others;
        if (m_owner >= 0) begin
            m_age++;
            if (m_age % P == 0) begin
                others = req;
                others[m_owner] = 1'b0;
                if (m_age / P >= HOLD && (!req[m_owner] || others != '0)) begin
                    m_ptr = (m_owner + 1) % N;
                    m_owner = -1; m_gap = 1; m_gap_age = 0;
                end else begin
                    m_dr = chan(m_owner, 0); m_dg = chan(m_owner, 1); m_db = chan(m_owner, 2);
                end
            end
        end else if (m_gap != 0) begin
            m_gap_age++;
            if (m_gap_age == P) begin
                m_gap = 0;
                model_grant();
            end
        end else begin
            model_grant();
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        int k;
        eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        k  = m_age % P;
        check({tag, ".grant"}, 32'(grant), 32'(eg));
        check({tag, ".red"},   32'(red),   32'(m_owner >= 0 && k < m_dr));
        check({tag, ".green"}, 32'(green), 32'(m_owner >= 0 && k < m_dg));
        check({tag, ".blue"},  32'(blue),  32'(m_owner >= 0 && k < m_db));
        check({tag, ".busy"},  32'(busy),  32'(m_owner >= 0 || m_gap != 0));
    endtask

    task automatic step(input string tag);
        model_next();
        @(negedge clk);
        check_model(tag);
    endtask

    // Called at a falling edge; reset lands mid-cycle, away from any rising edge
    task automatic async_reset(input string tag);
        #1 reset = 1'b1;
        model_reset();
        #1 check_model(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0]   rp, gp, bp;
        logic [7:0]   rp8;
        logic [N-1:0] prev_g;
        logic [N-1:0] seq [4];
        int           nseq, gcnt, gapcnt;

        reset = 1'b1;
        req   = '0;
        duty  = '0;
        model_reset();
        #2 check_model("reset_noclk");
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) step("idle");

        // Single owner, held; patterns from r=3,g=1,b=0
        set_duty(0, 3, 1, 0);
        req = 3'b001;
        rp = '0; gp = '0; bp = '0;
        for (int i = 0; i < 4; i++) begin
            step("show0");
            rp = {rp[2:0], red}; gp = {gp[2:0], green}; bp = {bp[2:0], blue};
        end
        check("latency_grant", 32'(grant), 32'(3'b001));
        check("pat_red",   32'(rp), 32'(4'b1110));
        check("pat_green", 32'(gp), 32'(4'b1000));
        check("pat_blue",  32'(bp), 32'(4'b0000));
        for (int c = 0; c < 36; c++) step("held");

        // Drop, drain to idle, then a one-clock pulse
        req = '0;
        for (int c = 0; c < 20; c++) step("drain");
        req = 3'b001;
        step("pulse");
        gcnt = (grant === 3'b001) ? 1 : 0;
        gapcnt = 0;
        req = '0;
        for (int c = 0; c < 15; c++) begin
            step("pulse_run");
            if (grant === 3'b001) gcnt++;
            if (busy === 1'b1 && grant === 3'b000) gapcnt++;
        end
        check("pulse_hold_len", 32'(gcnt), 32'(8));
        check("pulse_gap_len", 32'(gapcnt), 32'(4));
        check("pulse_idle_busy", 32'(busy), 32'(0));

        // All three requesting from reset: rotation order
        async_reset("reset_rr");
        req = 3'b111;
        set_duty(1, 2, 2, 2);
        set_duty(2, 1, 3, 0);
        prev_g = '0;
        nseq = 0;
        for (int c = 0; c < 40; c++) begin
            step("rr");
            if (grant !== 3'b000 && prev_g === 3'b000 && nseq < 4) begin
                seq[nseq] = grant;
                nseq++;
            end
            prev_g = grant;
        end
        check("rr_count", 32'(nseq), 32'(4));
        check("rr_1st", 32'(seq[0]), 32'(3'b001));
        check("rr_2nd", 32'(seq[1]), 32'(3'b010));
        check("rr_3rd", 32'(seq[2]), 32'(3'b100));
        check("rr_4th", 32'(seq[3]), 32'(3'b001));

        // Duty change at k=1 only takes effect next period
        async_reset("reset_glitch");
        set_duty(0, 3, 0, 0);
        req = 3'b001;
        rp8 = '0;
        for (int i = 0; i < 8; i++) begin
            step("glitch");
            rp8 = {rp8[6:0], red};
            if (i == 1) set_duty(0, 1, 0, 0);
        end
        check("glitch_red", 32'(rp8), 32'(8'b1110_1000));

        // Reset mid-show at k=2, owner 1; pointer returns to 0
        async_reset("reset_pre6");
        req = 3'b010;
        set_duty(1, 3, 3, 3);
        for (int i = 0; i < 3; i++) step("mid");
        check("mid_owner", 32'(grant), 32'(3'b010));
        async_reset("reset_mid");
        req = 3'b110;
        step("after_reset");
        check("after_reset_grant", 32'(grant), 32'(3'b010));
        for (int c = 0; c < 10; c++) step("after_run");

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) req = N'($urandom_range(0, 7));
            duty = DW'($urandom);
            step("rand");
            if (c == 200) async_reset("reset_rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
